store_buffer: RTL and testbench
===============================

// Module: store_buffer
// PURPOSE
// - Write buffer directly upstream of the data memory: CPU stores enter a small in-order FIFO and drain
//   to the memory write port one per cycle, decoupling store issue from memory-port availability.
// - Loads probe the buffer combinationally; the newest pending store to the same address is forwarded,
//   so no load ever returns data older than a store accepted before it.
// PARAMETERS
// - DEPTH   4  number of pending store entries (power of two, >= 2)
// - ADDR_W  8  address width, matches data memory address
// - DATA_W  8  data width, matches data memory word
// PORTS
// - clk            in   1       clock; all state updates on posedge
// - rst            in   1       synchronous, active-high reset
// - st_valid       in   1       CPU presents a store this cycle
// - st_addr        in   ADDR_W  store address
// - st_data        in   DATA_W  store data
// - st_ready       out  1       buffer accepts store this cycle (count < DEPTH)
// - ld_addr        in   ADDR_W  load address being read from memory this cycle
// - ld_hit         out  1       a pending entry matches ld_addr
// - ld_data        out  DATA_W  data of newest matching entry (0 when !ld_hit)
// - mem_hold       in   1       memory write port unavailable this cycle; suppresses drain
// - mem_writeEn    out  1       write strobe to data memory
// - mem_address    out  ADDR_W  write address to data memory
// - mem_writeData  out  DATA_W  write data to data memory
// - empty          out  1       no pending entries (CPU fence / halt condition)
// BEHAVIOUR
// - State: entry array {addr,data}, rd_ptr, wr_ptr (log2 DEPTH bits, wrap modulo DEPTH), count (0..DEPTH).
// - Reset (rst=1 at posedge): count=0, rd_ptr=wr_ptr=0; entry contents don't-care. Pending stores are
//   discarded; a store offered in the reset cycle is dropped. All outputs gated by !rst while rst high:
//   mem_writeEn=0, st_ready=0, ld_hit=0, ld_data=0, empty=1.
// - Push: st_valid && st_ready -> entry[wr_ptr]={st_addr,st_data}, wr_ptr+1 at the edge. 0-cycle accept.
// - Drain: mem_writeEn = (count>0) && !mem_hold && !rst, combinational from registered state;
//   mem_address/mem_writeData = entry[rd_ptr] (hold last head value, or 0 when empty).
//   On that edge memory captures the write and rd_ptr+1. Strict FIFO order; no coalescing.
// - count: +1 on push only, -1 on drain only, unchanged on simultaneous push+drain.
// - Full (count==DEPTH): st_ready=0 even if a drain happens this cycle (no same-cycle bypass).
// - Empty: store accepted this cycle is first visible on mem_writeEn the next cycle (min latency 1).
// - Forwarding: compare ld_addr with every valid entry (rd_ptr .. wr_ptr-1 in FIFO order); newest match
//   wins. The head entry being drained this cycle still forwards (memory not yet updated).
//   A store being pushed in the same cycle is NOT forwarded; CPU sequencing guarantees this.
// - Duplicate addresses: all entries kept, drained oldest first; forwarding picks youngest.
// - mem_hold held indefinitely: buffer fills to DEPTH, st_ready drops, contents preserved.
// - empty = (count==0); single-cycle CPU stalls on !st_ready for a store, fences on empty.
// STRUCTURE
// - Package store_buffer_pkg: ADDR_W/DATA_W defaults, DEPTH default, PTR_W = $clog2(DEPTH),
//   typedef sb_entry_t {logic [ADDR_W-1:0] addr; logic [DATA_W-1:0] data;}.
// - One sub-module: sb_forward_match -- combinational priority search (valid mask rotated by rd_ptr,
//   youngest-first) returning ld_hit/ld_data; FIFO pointers and drain logic stay in the top.
// TESTING
// - Reset then push {0x10,0xAA}: next cycle mem_writeEn=1, addr 0x10, data 0xAA; following cycle empty=1.
// - mem_hold=1, push 0x01..0x05 to addr 0x20..0x24: st_ready=0 after 4th; 5th not accepted; release hold
//   -> four writes in order 0x20..0x23 on consecutive cycles.
// - Push {0x30,0x11} then {0x30,0x22} with hold=1; ld_addr=0x30 -> ld_hit=1, ld_data=0x22; ld_addr=0x31 -> ld_hit=0.
// - count=2, push and drain same cycle -> count stays 2; wr_ptr/rd_ptr wrap from 3 to 0 correctly over 8 stores.
// - rst asserted with 3 entries pending -> mem_writeEn=0 that cycle, empty=1 after, no stale writes later.
// - Random stores/hold vs a reference memory model: final data memory contents equal model after drain.

Source files
------------

// File: rtl/store_buffer_pkg.sv
// Shared widths and entry layout for the store buffer and anything that
// models its pending stores.
package store_buffer_pkg;
  localparam int SB_DEPTH  = 4;
  localparam int SB_ADDR_W = 8;
  localparam int SB_DATA_W = 8;
  localparam int SB_PTR_W  = $clog2(SB_DEPTH);

  typedef struct packed {
    logic [SB_ADDR_W-1:0] addr;
    logic [SB_DATA_W-1:0] data;
  } sb_entry_t;
endpackage

// File: rtl/sb_forward_match.sv
// Load-to-store forwarding search: scans pending entries oldest to youngest
// starting at rd_ptr, so the youngest matching store ends up selected.
module sb_forward_match
  import store_buffer_pkg::*;
#(
  parameter int DEPTH  = SB_DEPTH,
  parameter int ADDR_W = SB_ADDR_W,
  parameter int DATA_W = SB_DATA_W,
  parameter int PTR_W  = $clog2(DEPTH),
  parameter int CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic [ADDR_W-1:0] entry_addr [DEPTH],
  input  logic [DATA_W-1:0] entry_data [DEPTH],
  input  logic [PTR_W-1:0]  rd_ptr,
  input  logic [CNT_W-1:0]  count,
  input  logic [ADDR_W-1:0] ld_addr,
  output logic              ld_hit,
  output logic [DATA_W-1:0] ld_data
);

  logic [PTR_W-1:0] age_idx [DEPTH];
  logic [DEPTH-1:0] match_rot;

  // Bit k of match_rot is the entry k places behind the head (k=0 oldest).
  always_comb begin
    for (int k = 0; k < DEPTH; k++) begin
      age_idx[k]   = rd_ptr + PTR_W'(k);
      match_rot[k] = (CNT_W'(k) < count) && (entry_addr[age_idx[k]] == ld_addr);
    end
  end

  always_comb begin
    ld_hit  = 1'b0;
    ld_data = '0;
    for (int k = 0; k < DEPTH; k++) begin
      if (match_rot[k]) begin
        ld_hit  = 1'b1;
        ld_data = entry_data[age_idx[k]];
      end
    end
  end

endmodule

// File: rtl/store_buffer.sv
// In-order store buffer ahead of the data memory write port: one push and
// one drain per cycle, with youngest-match forwarding to loads.
//
// Handshake: a store transfers on any posedge where st_valid && st_ready;
// st_ready depends only on registered state (never on st_valid or a
// same-cycle drain), and a drain transfers whenever mem_writeEn is high.
module store_buffer
  import store_buffer_pkg::*;
#(
  parameter int DEPTH  = SB_DEPTH,
  parameter int ADDR_W = SB_ADDR_W,
  parameter int DATA_W = SB_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              st_valid,
  input  logic [ADDR_W-1:0] st_addr,
  input  logic [DATA_W-1:0] st_data,
  output logic              st_ready,
  input  logic [ADDR_W-1:0] ld_addr,
  output logic              ld_hit,
  output logic [DATA_W-1:0] ld_data,
  input  logic              mem_hold,
  output logic              mem_writeEn,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_writeData,
  output logic              empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [ADDR_W-1:0] entry_addr [DEPTH];
  logic [DATA_W-1:0] entry_data [DEPTH];
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  wr_ptr;
  logic [CNT_W-1:0]  count;

  logic push;
  logic drain;
  logic fwd_hit;
  logic [DATA_W-1:0] fwd_data;

  assign st_ready    = !rst && (count != CNT_W'(DEPTH));
  assign push        = st_valid && st_ready;
  assign drain       = !rst && (count != '0) && !mem_hold;
  assign mem_writeEn = drain;
  assign empty       = rst || (count == '0);

  assign mem_address   = (count != '0) ? entry_addr[rd_ptr] : '0;
  assign mem_writeData = (count != '0) ? entry_data[rd_ptr] : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push)  wr_ptr <= wr_ptr + 1'b1;
      if (drain) rd_ptr <= rd_ptr + 1'b1;
      case ({push, drain})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Entry payloads carry no reset; only slots between the pointers are meaningful.
  always_ff @(posedge clk) begin
    if (push) begin
      entry_addr[wr_ptr] <= st_addr;
      entry_data[wr_ptr] <= st_data;
    end
  end

  sb_forward_match #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .PTR_W  (PTR_W),
    .CNT_W  (CNT_W)
  ) u_fwd (
    .entry_addr (entry_addr),
    .entry_data (entry_data),
    .rd_ptr     (rd_ptr),
    .count      (count),
    .ld_addr    (ld_addr),
    .ld_hit     (fwd_hit),
    .ld_data    (fwd_data)
  );

  assign ld_hit  = !rst && fwd_hit;
  assign ld_data = rst ? '0 : fwd_data;

endmodule

// File: tb/tb_store_buffer.sv
// Self-checking bench for store_buffer: directed scenarios plus a random
// run against a reference memory, with a pending-store scoreboard.
module tb_store_buffer;
  import store_buffer_pkg::*;

  localparam int AW = SB_ADDR_W;
  localparam int DW = SB_DATA_W;
  localparam int EW = AW + DW;

  logic          clk;
  logic          rst;
  logic          st_valid;
  logic [AW-1:0] st_addr;
  logic [DW-1:0] st_data;
  logic          st_ready;
  logic [AW-1:0] ld_addr;
  logic          ld_hit;
  logic [DW-1:0] ld_data;
  logic          mem_hold;
  logic          mem_writeEn;
  logic [AW-1:0] mem_address;
  logic [DW-1:0] mem_writeData;
  logic          empty;

  int checks   = 0;
  int failures = 0;

  logic [EW-1:0] exp_q[$];
  logic [DW-1:0] model_mem [256];
  logic [DW-1:0] dut_mem   [256];

  store_buffer dut (
    .clk           (clk),
    .rst           (rst),
    .st_valid      (st_valid),
    .st_addr       (st_addr),
    .st_data       (st_data),
    .st_ready      (st_ready),
    .ld_addr       (ld_addr),
    .ld_hit        (ld_hit),
    .ld_data       (ld_data),
    .mem_hold      (mem_hold),
    .mem_writeEn   (mem_writeEn),
    .mem_address   (mem_address),
    .mem_writeData (mem_writeData),
    .empty         (empty)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // ---------------- scoreboard / monitor ----------------
  // Sampled mid-cycle: forwarding is judged against stores pending before
  // this cycle, then the drain pops, then any accepted store is queued.
  always @(negedge clk) begin
    if (!rst) begin
      logic          exp_hit;
      logic [DW-1:0] exp_data;
      sb_entry_t     e;
      exp_hit  = 1'b0;
      exp_data = '0;
      for (int i = 0; i < exp_q.size(); i++) begin
        e = exp_q[i];
        if (e.addr == ld_addr) begin
          exp_hit  = 1'b1;
          exp_data = e.data;
        end
      end
      checks++;
      if (ld_hit !== exp_hit || ld_data !== exp_data) begin
        failures++;
        $display("FAIL fwd_model t=%0t ld_addr=%h got hit=%b data=%h exp hit=%b data=%h",
                 $time, ld_addr, ld_hit, ld_data, exp_hit, exp_data);
      end
      if (mem_writeEn === 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL drain_unexpected t=%0t got addr=%h data=%h exp no write",
                   $time, mem_address, mem_writeData);
        end else begin
          e = exp_q.pop_front();
          if (mem_address !== e.addr || mem_writeData !== e.data) begin
            failures++;
            $display("FAIL drain_order t=%0t got addr=%h data=%h exp addr=%h data=%h",
                     $time, mem_address, mem_writeData, e.addr, e.data);
          end
        end
        dut_mem[mem_address] = mem_writeData;
      end
      if (st_valid && st_ready) begin
        exp_q.push_back({st_addr, st_data});
        model_mem[st_addr] = st_data;
      end
    end else begin
      checks++;
      if (mem_writeEn !== 1'b0) begin
        failures++;
        $display("FAIL write_in_reset t=%0t got writeEn=%b exp 0", $time, mem_writeEn);
      end
    end
  end

  task automatic wait_empty(input string name);
    bit done;
    done = 1'b0;
    for (int n = 0; n < 40 && !done; n++) begin
      @(negedge clk);
      if (empty === 1'b1) done = 1'b1;
      else step();
    end
    checks++;
    if (!done) begin
      failures++;
      $display("FAIL %s_drain_timeout got empty=%b exp 1", name, empty);
    end
    step();
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b1; st_valid = 1'b1; st_addr = 8'h55; st_data = 8'h66;
    @(negedge clk);
    checks++;
    if (st_ready !== 1'b0 || empty !== 1'b1 || ld_hit !== 1'b0 || ld_data !== '0) begin
      failures++;
      $display("FAIL reset_outputs got ready=%b empty=%b hit=%b data=%h exp 0 1 0 00",
               st_ready, empty, ld_hit, ld_data);
    end
    step();
    rst = 1'b0; st_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (empty !== 1'b1 || mem_writeEn !== 1'b0) begin
      failures++;
      $display("FAIL reset_store_dropped got empty=%b writeEn=%b exp 1 0", empty, mem_writeEn);
    end
    step();
  endtask

  task automatic test_basic();
    st_valid = 1'b1; st_addr = 8'h10; st_data = 8'hAA;
    @(negedge clk);
    checks++;
    if (st_ready !== 1'b1) begin
      failures++;
      $display("FAIL basic_ready got %b exp 1", st_ready);
    end
    step();
    st_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (mem_writeEn !== 1'b1 || mem_address !== 8'h10 || mem_writeData !== 8'hAA) begin
      failures++;
      $display("FAIL basic_drain got en=%b addr=%h data=%h exp 1 10 aa",
               mem_writeEn, mem_address, mem_writeData);
    end
    step();
    @(negedge clk);
    checks++;
    if (empty !== 1'b1 || mem_writeEn !== 1'b0) begin
      failures++;
      $display("FAIL basic_empty got empty=%b en=%b exp 1 0", empty, mem_writeEn);
    end
    step();
  endtask

  task automatic test_full();
    mem_hold = 1'b1;
    for (int i = 0; i < 5; i++) begin
      st_valid = 1'b1; st_addr = 8'h20 + 8'(i); st_data = 8'h01 + 8'(i);
      @(negedge clk);
      checks++;
      if (st_ready !== (i < 4)) begin
        failures++;
        $display("FAIL full_ready_%0d got %b exp %b", i, st_ready, (i < 4));
      end
      step();
    end
    st_valid = 1'b0; ld_addr = 8'h22;
    @(negedge clk);
    checks++;
    if (mem_writeEn !== 1'b0 || ld_hit !== 1'b1 || ld_data !== 8'h03) begin
      failures++;
      $display("FAIL full_hold got en=%b hit=%b data=%h exp 0 1 03", mem_writeEn, ld_hit, ld_data);
    end
    step();
    // Full while draining: the offered store must still be refused.
    mem_hold = 1'b0; st_valid = 1'b1; st_addr = 8'h25; st_data = 8'h06;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (i == 0) begin
        checks++;
        if (st_ready !== 1'b0) begin
          failures++;
          $display("FAIL full_no_bypass got ready=%b exp 0", st_ready);
        end
      end
      checks++;
      if (mem_writeEn !== 1'b1 || mem_address !== 8'h20 + 8'(i) || mem_writeData !== 8'h01 + 8'(i)) begin
        failures++;
        $display("FAIL full_release_%0d got en=%b addr=%h data=%h exp 1 %h %h",
                 i, mem_writeEn, mem_address, mem_writeData, 8'h20 + 8'(i), 8'h01 + 8'(i));
      end
      step();
      st_valid = 1'b0;
    end
    @(negedge clk);
    checks++;
    if (empty !== 1'b1) begin
      failures++;
      $display("FAIL full_final_empty got %b exp 1", empty);
    end
    step();
  endtask

  task automatic test_forward();
    mem_hold = 1'b1;
    st_valid = 1'b1; st_addr = 8'h30; st_data = 8'h11;
    step();
    st_data = 8'h22;
    step();
    st_valid = 1'b0; ld_addr = 8'h30;
    @(negedge clk);
    checks++;
    if (ld_hit !== 1'b1 || ld_data !== 8'h22) begin
      failures++;
      $display("FAIL fwd_youngest got hit=%b data=%h exp 1 22", ld_hit, ld_data);
    end
    step();
    ld_addr = 8'h31;
    @(negedge clk);
    checks++;
    if (ld_hit !== 1'b0 || ld_data !== 8'h00) begin
      failures++;
      $display("FAIL fwd_miss got hit=%b data=%h exp 0 00", ld_hit, ld_data);
    end
    step();
    st_valid = 1'b1; st_addr = 8'h31; st_data = 8'h33;
    @(negedge clk);
    checks++;
    if (ld_hit !== 1'b0) begin
      failures++;
      $display("FAIL fwd_same_cycle_push got hit=%b exp 0", ld_hit);
    end
    step();
    st_valid = 1'b0; mem_hold = 1'b0; ld_addr = 8'h30;
    @(negedge clk);
    checks++;
    if (mem_writeEn !== 1'b1 || ld_hit !== 1'b1 || ld_data !== 8'h22) begin
      failures++;
      $display("FAIL fwd_during_drain got en=%b hit=%b data=%h exp 1 1 22", mem_writeEn, ld_hit, ld_data);
    end
    step();
    wait_empty("fwd");
    st_valid = 1'b1; st_addr = 8'h40; st_data = 8'h44;
    step();
    st_valid = 1'b0; ld_addr = 8'h40;
    @(negedge clk);
    checks++;
    if (mem_writeEn !== 1'b1 || ld_hit !== 1'b1 || ld_data !== 8'h44) begin
      failures++;
      $display("FAIL fwd_head_drain got en=%b hit=%b data=%h exp 1 1 44", mem_writeEn, ld_hit, ld_data);
    end
    step();
    ld_addr = 8'h00;
    wait_empty("fwd_head");
  endtask

  task automatic test_back_to_back();
    mem_hold = 1'b1; st_valid = 1'b1;
    st_addr = 8'h50; st_data = 8'hB0;
    step();
    st_addr = 8'h51; st_data = 8'hB1;
    step();
    mem_hold = 1'b0;
    for (int i = 0; i < 8; i++) begin
      st_addr = 8'h60 + 8'(i); st_data = 8'hC0 + 8'(i);
      @(negedge clk);
      checks++;
      if (st_ready !== 1'b1 || mem_writeEn !== 1'b1 || empty !== 1'b0) begin
        failures++;
        $display("FAIL b2b_steady_%0d got ready=%b en=%b empty=%b exp 1 1 0", i, st_ready, mem_writeEn, empty);
      end
      step();
    end
    st_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checks++;
      if (mem_writeEn !== 1'b1 || mem_address !== 8'h66 + 8'(i)) begin
        failures++;
        $display("FAIL b2b_tail_%0d got en=%b addr=%h exp 1 %h", i, mem_writeEn, mem_address, 8'h66 + 8'(i));
      end
      step();
    end
    @(negedge clk);
    checks++;
    if (empty !== 1'b1) begin
      failures++;
      $display("FAIL b2b_empty got %b exp 1", empty);
    end
    step();
  endtask

  task automatic test_reset_pending();
    mem_hold = 1'b1; st_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      st_addr = 8'h70 + 8'(i); st_data = 8'hD0 + 8'(i);
      step();
    end
    st_valid = 1'b0; mem_hold = 1'b0; rst = 1'b1;
    @(negedge clk);
    checks++;
    if (mem_writeEn !== 1'b0 || empty !== 1'b1) begin
      failures++;
      $display("FAIL rstp_during got en=%b empty=%b exp 0 1", mem_writeEn, empty);
    end
    exp_q.delete();
    step();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if (mem_writeEn !== 1'b0 || empty !== 1'b1) begin
        failures++;
        $display("FAIL rstp_after_%0d got en=%b empty=%b exp 0 1", i, mem_writeEn, empty);
      end
      step();
    end
  endtask

  task automatic test_random();
    for (int a = 0; a < 256; a++) begin
      model_mem[a] = '0;
      dut_mem[a]   = '0;
    end
    for (int n = 0; n < 300; n++) begin
      st_valid = 1'($urandom_range(0, 1));
      st_addr  = 8'($urandom_range(0, 15));
      st_data  = 8'($urandom_range(0, 255));
      mem_hold = ($urandom_range(0, 3) == 0);
      ld_addr  = 8'($urandom_range(0, 15));
      step();
    end
    st_valid = 1'b0; mem_hold = 1'b0;
    wait_empty("rand");
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL rand_queue_left got %0d exp 0", exp_q.size());
    end
    for (int a = 0; a < 256; a++) begin
      checks++;
      if (dut_mem[a] !== model_mem[a]) begin
        failures++;
        $display("FAIL rand_mem[%h] got %h exp %h", a, dut_mem[a], model_mem[a]);
      end
    end
  endtask

  initial begin
    rst = 1'b1; st_valid = 1'b0; st_addr = '0; st_data = '0;
    ld_addr = '0; mem_hold = 1'b0;
    step();
    step();
    test_reset();
    test_basic();
    test_full();
    test_forward();
    test_back_to_back();
    test_reset_pending();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
